// File: rtl/vga_filter_pkg.sv
// Shared types and arithmetic helpers for the VGA gradient filter.
package vga_filter_pkg;

  localparam int PIX_DW = 8;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_HDIFF = 2'd1,
    MODE_VDIFF = 2'd2,
    MODE_SUM   = 2'd3
  } mode_t;

  typedef struct packed {
    logic [PIX_DW-1:0] r;
    logic [PIX_DW-1:0] g;
    logic [PIX_DW-1:0] b;
    logic              hs;
    logic              vs;
    logic              sync_n;
    logic              blank_n;
  } vga_pix_t;

  // Blanked pixel with syncs inactive; the value every pipeline register resets to.
  localparam vga_pix_t PIX_IDLE = '{r: '0, g: '0, b: '0, hs: 1'b1, vs: 1'b1,
                                    sync_n: 1'b0, blank_n: 1'b0};

  function automatic logic [PIX_DW-1:0] absdiff(input logic [PIX_DW-1:0] a,
                                                input logic [PIX_DW-1:0] b);
    logic signed [PIX_DW:0] d;
    logic signed [PIX_DW:0] m;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    m = (d < 0) ? -d : d;
    return m[PIX_DW-1:0];
  endfunction

  function automatic logic [PIX_DW-1:0] sat_add(input logic [PIX_DW-1:0] a,
                                                input logic [PIX_DW-1:0] b);
    logic [PIX_DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PIX_DW] ? {PIX_DW{1'b1}} : s[PIX_DW-1:0];
  endfunction

endpackage

// File: rtl/vga_line_buffer.sv
// One-line pixel store: simple dual-port RAM, registered read, read-before-write.
module vga_line_buffer #(
  parameter int DEPTH = 640,
  parameter int AW    = 10,
  parameter int DW    = 24
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Single clocked process so the RAM maps onto a block memory; the read sees the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_gradient_filter.sv
// Streaming per-pixel horizontal/vertical gradient filter with optional threshold,
// two-cycle fixed latency on colour and sync.
module vga_gradient_filter
  import vga_filter_pkg::*;
#(
  parameter int WIDTH = 640,
  parameter int DW    = PIX_DW
) (
  input  logic          VGA_CLK,
  input  logic          reset_n,
  input  logic [DW-1:0] iVGA_R,
  input  logic [DW-1:0] iVGA_G,
  input  logic [DW-1:0] iVGA_B,
  input  logic          iVGA_HS,
  input  logic          iVGA_VS,
  input  logic          iVGA_SYNC_N,
  input  logic          iVGA_BLANK_N,
  input  mode_t         mode_r,
  input  mode_t         mode_g,
  input  mode_t         mode_b,
  input  logic          thresh_en,
  input  logic [DW-1:0] thresh,
  output logic [DW-1:0] oVGA_R,
  output logic [DW-1:0] oVGA_G,
  output logic [DW-1:0] oVGA_B,
  output logic          oVGA_HS,
  output logic          oVGA_VS,
  output logic          oVGA_SYNC_N,
  output logic          oVGA_BLANK_N,
  output logic          line_ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = $clog2(WIDTH);

  function automatic logic [DW-1:0] binarise(input logic [DW-1:0] v,
                                             input logic [DW-1:0] t);
    return (v >= t) ? {DW{1'b1}} : {DW{1'b0}};
  endfunction

  vga_pix_t          pix_in;
  vga_pix_t          pix_p1_q;
  logic [3*DW-1:0]   prev_rgb_p1_q;
  logic              prev_blank_p1_q;
  logic              ovf_p1_q;
  vga_pix_t          out_p2_q;
  logic              ovf_p2_q;

  logic [CW-1:0]     col_q, col_d;
  logic              first_line_q, first_line_d;
  logic              vs_seen_q, vs_seen_d;
  logic              col_full;

  logic              lb_we;
  logic [AW-1:0]     lb_addr;
  logic [3*DW-1:0]   lb_rdata;

  assign pix_in = '{r: iVGA_R, g: iVGA_G, b: iVGA_B, hs: iVGA_HS, vs: iVGA_VS,
                    sync_n: iVGA_SYNC_N, blank_n: iVGA_BLANK_N};

  assign col_full = (col_q == CW'(WIDTH));
  assign lb_we    = pix_in.blank_n && !col_full;
  assign lb_addr  = col_full ? '0 : col_q[AW-1:0];

  vga_line_buffer #(
    .DEPTH (WIDTH),
    .AW    (AW),
    .DW    (3 * DW)
  ) u_line_buffer (
    .clk_i   (VGA_CLK),
    .we_i    (lb_we),
    .waddr_i (lb_addr),
    .wdata_i ({pix_in.r, pix_in.g, pix_in.b}),
    .raddr_i (lb_addr),
    .rdata_o (lb_rdata)
  );

  // First line is only released once a vsync has been seen since reset, so a
  // mid-frame reset keeps dy masked until the next frame's second line.
  always_comb begin
    col_d        = col_q;
    first_line_d = first_line_q;
    vs_seen_d    = vs_seen_q | ~pix_in.vs;
    if (!pix_in.blank_n) begin
      col_d = '0;
    end else if (!col_full) begin
      col_d = col_q + 1'b1;
    end
    if (!pix_in.vs) begin
      first_line_d = 1'b1;
    end else if (vs_seen_q && pix_p1_q.blank_n && !pix_in.blank_n) begin
      first_line_d = 1'b0;
    end
  end

  // ---- stage 1: capture pixel, previous pixel and line-buffer read ----
  always_ff @(posedge VGA_CLK) begin
    if (!reset_n) begin
      pix_p1_q        <= PIX_IDLE;
      prev_rgb_p1_q   <= '0;
      prev_blank_p1_q <= 1'b0;
      ovf_p1_q        <= 1'b0;
      col_q           <= '0;
      first_line_q    <= 1'b1;
      vs_seen_q       <= 1'b0;
    end else begin
      pix_p1_q        <= pix_in;
      prev_rgb_p1_q   <= {pix_p1_q.r, pix_p1_q.g, pix_p1_q.b};
      prev_blank_p1_q <= pix_p1_q.blank_n;
      ovf_p1_q        <= pix_in.blank_n && col_full;
      col_q           <= col_d;
      first_line_q    <= first_line_d;
      vs_seen_q       <= vs_seen_d;
    end
  end

  logic [DW-1:0] s1_ch   [3];
  logic [DW-1:0] prev_ch [3];
  logic [DW-1:0] lb_ch   [3];
  logic [DW-1:0] res_ch  [3];
  mode_t         mode_ch [3];

  assign s1_ch[0]   = pix_p1_q.r;
  assign s1_ch[1]   = pix_p1_q.g;
  assign s1_ch[2]   = pix_p1_q.b;
  assign prev_ch[0] = prev_rgb_p1_q[3*DW-1:2*DW];
  assign prev_ch[1] = prev_rgb_p1_q[2*DW-1:DW];
  assign prev_ch[2] = prev_rgb_p1_q[DW-1:0];
  assign lb_ch[0]   = lb_rdata[3*DW-1:2*DW];
  assign lb_ch[1]   = lb_rdata[2*DW-1:DW];
  assign lb_ch[2]   = lb_rdata[DW-1:0];
  assign mode_ch[0] = mode_r;
  assign mode_ch[1] = mode_g;
  assign mode_ch[2] = mode_b;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [DW-1:0] dx, dy, val, val_t;
    // An overflow pixel has no line-buffer slot, so it is compared with itself.
    always_comb begin
      dx = prev_blank_p1_q ? absdiff(s1_ch[c], prev_ch[c]) : '0;
      dy = (first_line_q || ovf_p1_q) ? '0 : absdiff(s1_ch[c], lb_ch[c]);
      case (mode_ch[c])
        MODE_HDIFF: val = dx;
        MODE_VDIFF: val = dy;
        MODE_SUM:   val = sat_add(dx, dy);
        default:    val = s1_ch[c];
      endcase
      val_t = thresh_en ? binarise(val, thresh) : val;
    end
    assign res_ch[c] = pix_p1_q.blank_n ? val_t : '0;
  end

  // ---- stage 2: filtered colour plus delayed sync ----
  always_ff @(posedge VGA_CLK) begin
    if (!reset_n) begin
      out_p2_q <= PIX_IDLE;
      ovf_p2_q <= 1'b0;
    end else begin
      out_p2_q <= '{r: res_ch[0], g: res_ch[1], b: res_ch[2], hs: pix_p1_q.hs,
                    vs: pix_p1_q.vs, sync_n: pix_p1_q.sync_n,
                    blank_n: pix_p1_q.blank_n};
      ovf_p2_q <= ovf_p1_q;
    end
  end

  assign oVGA_R       = out_p2_q.r;
  assign oVGA_G       = out_p2_q.g;
  assign oVGA_B       = out_p2_q.b;
  assign oVGA_HS      = out_p2_q.hs;
  assign oVGA_VS      = out_p2_q.vs;
  assign oVGA_SYNC_N  = out_p2_q.sync_n;
  assign oVGA_BLANK_N = out_p2_q.blank_n;
  assign line_ovf     = ovf_p2_q;

endmodule

// File: tb/tb_vga_gradient_filter.sv
// Directed bench: scaled 10x10 VGA frames through a WIDTH=10 and a WIDTH=8 filter.
module tb_vga_gradient_filter;
  import vga_filter_pkg::*;

  localparam int WIDTH  = 10;
  localparam int HEIGHT = 10;
  localparam int H_TOT  = 17;
  localparam int V_ACT0 = 5;
  localparam int V_TOT  = V_ACT0 + HEIGHT;

  logic       VGA_CLK = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] iR, iG, iB, thresh;
  logic       iHS, iVS, iSYNC, iBLANK, thresh_en;
  mode_t      mode_r, mode_g, mode_b;
  logic [7:0] aR, aG, aB, bR, bG, bB;
  logic       aHS, aVS, aSY, aBL, aOVF, bHS, bVS, bSY, bBL, bOVF;

  vga_gradient_filter #(.WIDTH(WIDTH), .DW(8)) dut (
    .VGA_CLK(VGA_CLK), .reset_n(reset_n), .iVGA_R(iR), .iVGA_G(iG), .iVGA_B(iB),
    .iVGA_HS(iHS), .iVGA_VS(iVS), .iVGA_SYNC_N(iSYNC), .iVGA_BLANK_N(iBLANK),
    .mode_r(mode_r), .mode_g(mode_g), .mode_b(mode_b), .thresh_en(thresh_en),
    .thresh(thresh), .oVGA_R(aR), .oVGA_G(aG), .oVGA_B(aB), .oVGA_HS(aHS),
    .oVGA_VS(aVS), .oVGA_SYNC_N(aSY), .oVGA_BLANK_N(aBL), .line_ovf(aOVF));

  vga_gradient_filter #(.WIDTH(8), .DW(8)) dut8 (
    .VGA_CLK(VGA_CLK), .reset_n(reset_n), .iVGA_R(iR), .iVGA_G(iG), .iVGA_B(iB),
    .iVGA_HS(iHS), .iVGA_VS(iVS), .iVGA_SYNC_N(iSYNC), .iVGA_BLANK_N(iBLANK),
    .mode_r(mode_r), .mode_g(mode_g), .mode_b(mode_b), .thresh_en(thresh_en),
    .thresh(thresh), .oVGA_R(bR), .oVGA_G(bG), .oVGA_B(bB), .oVGA_HS(bHS),
    .oVGA_VS(bVS), .oVGA_SYNC_N(bSY), .oVGA_BLANK_N(bBL), .line_ovf(bOVF));

  always #20 VGA_CLK = ~VGA_CLK;

  typedef struct {
    int x; int y; bit act; bit hs; bit vs; bit dyok; bit cut;
  } rec_t;

  int   n_chk = 0;
  int   n_err = 0;
  int   pat   = 0;
  bit   chk2  = 0;
  bit   dy_block = 0;
  bit   line_cut = 0;
  bit   rst_cur  = 0;
  bit   rst_last = 0;
  rec_t cur, last;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pattern: ramp R=x G=y B=x+y, or (pat=1) R checkerboard 0/200.
  function automatic int pval(int c, int x, int y);
    if (c == 0) return (pat != 0) ? (((x + y) % 2 != 0) ? 200 : 0) : x;
    if (c == 1) return y;
    return x + y;
  endfunction

  // Hand-derived neighbour differences of the pattern.
  function automatic int step_h(int c);
    if (c == 0) return (pat != 0) ? 200 : 1;
    if (c == 1) return 0;
    return 1;
  endfunction

  function automatic int step_v(int c);
    if (c == 0) return (pat != 0) ? 200 : 0;
    return 1;
  endfunction

  function automatic int ch_exp(int c, mode_t md, rec_t p);
    int dx, dy, r;
    dx = (p.x > 0) ? step_h(c) : 0;
    dy = (p.y > 0 && p.dyok) ? step_v(c) : 0;
    case (md)
      MODE_PASS:  r = pval(c, p.x, p.y);
      MODE_HDIFF: r = dx;
      MODE_VDIFF: r = dy;
      default:    r = (dx + dy > 255) ? 255 : dx + dy;
    endcase
    if (thresh_en) r = (r >= int'(thresh)) ? 255 : 0;
    return p.act ? r : 0;
  endfunction

  task automatic check_outputs();
    string at;
    at = $sformatf("x%0d y%0d", last.x, last.y);
    if (!rst_cur || !rst_last) begin
      chk({"rst R ", at}, aR, 0);
      chk({"rst G ", at}, aG, 0);
      chk({"rst B ", at}, aB, 0);
      chk({"rst HS ", at}, aHS, 1);
      chk({"rst VS ", at}, aVS, 1);
      chk({"rst SYNC ", at}, aSY, 0);
      chk({"rst BLANK ", at}, aBL, 0);
      chk({"rst ovf ", at}, aOVF, 0);
      chk({"rst ovf8 ", at}, bOVF, 0);
    end else begin
      chk({"oR ", at}, aR, ch_exp(0, mode_r, last));
      chk({"oG ", at}, aG, ch_exp(1, mode_g, last));
      chk({"oB ", at}, aB, ch_exp(2, mode_b, last));
      chk({"HS ", at}, aHS, int'(last.hs));
      chk({"VS ", at}, aVS, int'(last.vs));
      chk({"SYNC ", at}, aSY, 0);
      chk({"BLANK ", at}, aBL, int'(last.act));
      chk({"ovf ", at}, aOVF, 0);
      chk({"ovf8 ", at}, bOVF, (last.act && last.x >= 8 && !last.cut) ? 1 : 0);
      if (chk2)
        chk({"oG8 ", at}, bG,
            (last.act && last.y > 0 && last.x < 8 && last.dyok) ? 1 : 0);
    end
  endtask

  task automatic step(input int h, input int v, input bit rst_n);
    if (h == 0) line_cut = 0;
    if (!rst_n) begin
      dy_block = 1;
      line_cut = 1;
    end
    cur.x    = h;
    cur.y    = v - V_ACT0;
    cur.act  = (h < WIDTH) && (v >= V_ACT0);
    cur.hs   = !(h >= 12 && h <= 14);
    cur.vs   = !(v == 1 || v == 2);
    cur.dyok = !dy_block;
    cur.cut  = line_cut;
    reset_n  = rst_n;
    iR       = cur.act ? 8'(pval(0, cur.x, cur.y)) : 8'd0;
    iG       = cur.act ? 8'(pval(1, cur.x, cur.y)) : 8'd0;
    iB       = cur.act ? 8'(pval(2, cur.x, cur.y)) : 8'd0;
    iHS      = cur.hs;
    iVS      = cur.vs;
    iSYNC    = 1'b0;
    iBLANK   = cur.act;
    rst_cur  = rst_n;
    @(posedge VGA_CLK);
    #1;
    check_outputs();
    last     = cur;
    rst_last = rst_cur;
  endtask

  // One frame: front porch line, 2 vsync lines, back porch line(s), active rows.
  task automatic run_frame(input int rst_row, input int rst_x);
    bit r;
    for (int v = 0; v < V_TOT; v++) begin
      for (int h = 0; h < H_TOT; h++) begin
        if (v == 0 && h == 0) dy_block = 0;
        r = !(rst_row >= 0 && v == V_ACT0 + rst_row && h >= rst_x && h < rst_x + 3);
        step(h, v, r);
      end
    end
  endtask

  initial begin
    mode_r = MODE_PASS; mode_g = MODE_PASS; mode_b = MODE_PASS;
    thresh_en = 1'b0; thresh = 8'd0;
    last = '{x: 0, y: 0, act: 0, hs: 1, vs: 1, dyok: 0, cut: 0};
    for (int i = 0; i < 4; i++) step(i, 0, 1'b0);

    // All PASS: outputs are inputs delayed by two cycles.
    run_frame(-1, 0);

    // HDIFF on R, VDIFF on G, SUM on B.
    mode_r = MODE_HDIFF; mode_g = MODE_VDIFF; mode_b = MODE_SUM; chk2 = 1;
    run_frame(-1, 0);

    // Threshold at 2 applied to every channel.
    mode_r = MODE_PASS; mode_g = MODE_PASS; mode_b = MODE_SUM; chk2 = 0;
    thresh_en = 1'b1; thresh = 8'd2;
    run_frame(-1, 0);

    // Checkerboard 0/200 on R with SUM saturating at 255.
    thresh_en = 1'b0; pat = 1;
    mode_r = MODE_SUM; mode_g = MODE_PASS; mode_b = MODE_PASS;
    run_frame(-1, 0);

    // Reset for 3 cycles mid row 4, then the following frame recovers dy.
    pat = 0; mode_r = MODE_PASS; mode_g = MODE_VDIFF; mode_b = MODE_PASS;
    run_frame(4, 5);
    chk2 = 1;
    run_frame(-1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
